// File: rtl/dm_pkg.sv
`default_nettype none
// ============================================================================
// Module   : dm_pkg
// Purpose  : Shared encodings, FSM states and lane helpers for data_mem_ctrl.
// Revision : 1.0 - initial release
// ============================================================================
package dm_pkg;

    localparam logic [1:0] WIDTH_WORD = 2'd0;
    localparam logic [1:0] WIDTH_HALF = 2'd1;
    localparam logic [1:0] WIDTH_BYTE = 2'd2;

    typedef enum logic [1:0] {
        ST_INIT = 2'd0,
        ST_IDLE = 2'd1,
        ST_WAIT = 2'd2,
        ST_RESP = 2'd3
    } dm_state_e;

    function automatic logic req_error(input logic [1:0] width, input logic [1:0] lane);
        case (width)
            WIDTH_WORD: return (lane != 2'b00);
            WIDTH_HALF: return lane[0];
            WIDTH_BYTE: return 1'b0;
            default:    return 1'b1;
        endcase
    endfunction

    function automatic logic [3:0] byte_en(input logic [1:0] width, input logic [1:0] lane);
        case (width)
            WIDTH_WORD: return 4'b1111;
            WIDTH_HALF: return lane[1] ? 4'b1100 : 4'b0011;
            WIDTH_BYTE: return 4'b0001 << lane;
            default:    return 4'b0000;
        endcase
    endfunction

    // Store data replicated across every lane so the byte enables pick the right copy.
    function automatic logic [31:0] store_lanes(input logic [31:0] wdata, input logic [1:0] width);
        case (width)
            WIDTH_HALF: return {2{wdata[15:0]}};
            WIDTH_BYTE: return {4{wdata[7:0]}};
            default:    return wdata;
        endcase
    endfunction

    function automatic logic [31:0] lane_merge(input logic [31:0] old_word,
                                               input logic [31:0] new_word,
                                               input logic [3:0]  be);
        logic [31:0] merged;
        for (int i = 0; i < 4; i++) begin
            merged[8*i +: 8] = be[i] ? new_word[8*i +: 8] : old_word[8*i +: 8];
        end
        return merged;
    endfunction

    function automatic logic [31:0] load_extract(input logic [31:0] word,
                                                 input logic [1:0]  width,
                                                 input logic [1:0]  lane,
                                                 input logic        sign);
        logic [15:0] half;
        logic [7:0]  byt;
        half = lane[1] ? word[31:16] : word[15:0];
        byt  = word[8*lane +: 8];
        case (width)
            WIDTH_HALF: return {{16{sign & half[15]}}, half};
            WIDTH_BYTE: return {{24{sign & byt[7]}}, byt};
            default:    return word;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/dm_ram.sv
`default_nettype none
// ============================================================================
// Module   : dm_ram
// Purpose  : Word-wide RAM, byte-enable write, read-first synchronous read.
// Revision : 1.0 - initial release
// ============================================================================
module dm_ram #(
    parameter int DEPTH_WORDS = 4096,
    parameter int AW          = $clog2(DEPTH_WORDS)
) (
    input  logic          clk,
    input  logic          i_we,
    input  logic [3:0]    i_be,
    input  logic [AW-1:0] i_waddr,
    input  logic [31:0]   i_wdata,
    input  logic [AW-1:0] i_raddr,
    output logic [31:0]   o_rdata
);

    logic [31:0] r_mem [DEPTH_WORDS];
    logic [31:0] r_rdata;

    // Read returns the pre-write contents when read and write hit the same word.
    always_ff @(posedge clk) begin
        r_rdata <= r_mem[i_raddr];
        if (i_we) begin
            for (int i = 0; i < 4; i++) begin
                if (i_be[i]) begin
                    r_mem[i_waddr][8*i +: 8] <= i_wdata[8*i +: 8];
                end
            end
        end
    end

    assign o_rdata = r_rdata;

endmodule
`default_nettype wire

// File: rtl/data_mem_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : data_mem_ctrl
// Purpose  : Word/half/byte load-store unit with latency FSM, clear sequencer
//            and write trace port.
// Revision : 1.0 - initial release
// ============================================================================
module data_mem_ctrl
    import dm_pkg::*;
#(
    parameter int DEPTH_WORDS    = 4096,
    parameter int RD_LAT         = 1,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_req_valid,
    output logic        o_req_ready,
    input  logic        i_req_we,
    input  logic [1:0]  i_req_width,
    input  logic        i_req_sign,
    input  logic [31:0] i_req_addr,
    input  logic [31:0] i_req_wdata,
    input  logic [31:0] i_req_pc,
    output logic        o_rsp_valid,
    output logic [31:0] o_rsp_rdata,
    output logic        o_rsp_err,
    output logic        o_wr_log_valid,
    output logic [31:0] o_wr_log_pc,
    output logic [31:0] o_wr_log_addr,
    output logic [31:0] o_wr_log_data,
    output logic        o_init_busy
);

    localparam int            AW          = $clog2(DEPTH_WORDS);
    localparam logic [AW-1:0] LAST_IDX    = AW'(DEPTH_WORDS - 1);
    localparam logic [2:0]    CNT_START   = 3'(RD_LAT - 1);
    localparam dm_state_e     RESET_STATE = (CLEAR_ON_RESET != 0) ? ST_INIT : ST_IDLE;

    dm_state_e     r_state;
    dm_state_e     w_next_state;
    logic [2:0]    r_lat_cnt;
    logic [2:0]    w_next_cnt;
    logic [AW-1:0] r_clr_idx;

    logic          r_we;
    logic [1:0]    r_width;
    logic          r_sign;
    logic [31:0]   r_addr;
    logic [31:0]   r_wdata;
    logic [31:0]   r_pc;
    logic          r_err;

    logic          w_accept;
    logic          w_req_err;
    logic          w_resp;
    logic          w_log;
    logic          w_ram_we;
    logic [3:0]    w_ram_be;
    logic [AW-1:0] w_ram_waddr;
    logic [AW-1:0] w_ram_raddr;
    logic [31:0]   w_ram_wdata;
    logic [31:0]   w_ram_rdata;

    assign o_req_ready = (r_state == ST_IDLE) && rst_n;
    assign w_accept    = i_req_valid && o_req_ready;
    assign w_req_err   = req_error(i_req_width, i_req_addr[1:0]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= RESET_STATE;
            r_lat_cnt <= '0;
            r_clr_idx <= '0;
        end else begin
            r_state   <= w_next_state;
            r_lat_cnt <= w_next_cnt;
            if (r_state == ST_INIT) begin
                r_clr_idx <= r_clr_idx + 1'b1;
            end
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_next_cnt   = r_lat_cnt;
        case (r_state)
            ST_INIT: begin
                if (r_clr_idx == LAST_IDX) w_next_state = ST_IDLE;
            end
            ST_IDLE: begin
                if (w_accept) begin
                    if (w_req_err || i_req_we || (RD_LAT == 1)) begin
                        w_next_state = ST_RESP;
                    end else begin
                        w_next_state = ST_WAIT;
                        w_next_cnt   = CNT_START;
                    end
                end
            end
            ST_WAIT: begin
                if (r_lat_cnt == 3'd1) w_next_state = ST_RESP;
                else                   w_next_cnt   = r_lat_cnt - 3'd1;
            end
            ST_RESP: w_next_state = ST_IDLE;
            default: w_next_state = ST_IDLE;
        endcase
    end

    // Request fields are held for the whole life of the outstanding response.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_we    <= 1'b0;
            r_width <= WIDTH_WORD;
            r_sign  <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_pc    <= '0;
            r_err   <= 1'b0;
        end else if (w_accept) begin
            r_we    <= i_req_we;
            r_width <= i_req_width;
            r_sign  <= i_req_sign;
            r_addr  <= i_req_addr;
            r_wdata <= i_req_wdata;
            r_pc    <= i_req_pc;
            r_err   <= w_req_err;
        end
    end

    // Clear sequencer owns the write port during INIT.
    assign w_ram_we    = (r_state == ST_INIT) || (w_accept && i_req_we && !w_req_err);
    assign w_ram_be    = (r_state == ST_INIT) ? 4'b1111 : byte_en(i_req_width, i_req_addr[1:0]);
    assign w_ram_waddr = (r_state == ST_INIT) ? r_clr_idx : i_req_addr[AW+1:2];
    assign w_ram_wdata = (r_state == ST_INIT) ? 32'h0 : store_lanes(i_req_wdata, i_req_width);
    assign w_ram_raddr = (r_state == ST_IDLE) ? i_req_addr[AW+1:2] : r_addr[AW+1:2];

    dm_ram #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .AW          (AW)
    ) u_ram (
        .clk     (clk),
        .i_we    (w_ram_we),
        .i_be    (w_ram_be),
        .i_waddr (w_ram_waddr),
        .i_wdata (w_ram_wdata),
        .i_raddr (w_ram_raddr),
        .o_rdata (w_ram_rdata)
    );

    // For stores the RAM output holds the pre-write word, so the trace re-merges it.
    assign w_resp         = (r_state == ST_RESP);
    assign w_log          = w_resp && r_we && !r_err;
    assign o_rsp_valid    = w_resp;
    assign o_rsp_err      = w_resp && r_err;
    assign o_rsp_rdata    = (w_resp && !r_we && !r_err)
                          ? load_extract(w_ram_rdata, r_width, r_addr[1:0], r_sign) : 32'h0;
    assign o_wr_log_valid = w_log;
    assign o_wr_log_pc    = w_log ? r_pc : 32'h0;
    assign o_wr_log_addr  = w_log ? {r_addr[31:2], 2'b00} : 32'h0;
    assign o_wr_log_data  = w_log ? lane_merge(w_ram_rdata, store_lanes(r_wdata, r_width),
                                               byte_en(r_width, r_addr[1:0])) : 32'h0;
    assign o_init_busy    = (r_state == ST_INIT);

endmodule
`default_nettype wire

// File: tb/tb_data_mem_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_data_mem_ctrl
// Purpose  : Directed bench; DUT A has RD_LAT=1, DUT B has RD_LAT=3.
// Revision : 1.0 - initial release
// ============================================================================
module tb_data_mem_ctrl;

    localparam logic [1:0] W = 2'd0;
    localparam logic [1:0] H = 2'd1;
    localparam logic [1:0] B = 2'd2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, sel;
    logic        req_valid, req_we, req_sign;
    logic [1:0]  req_width;
    logic [31:0] req_addr, req_wdata, req_pc;

    logic        a_ready, a_rsp_valid, a_rsp_err, a_wlv, a_busy;
    logic [31:0] a_rdata, a_wlpc, a_wla, a_wld;
    logic        b_ready, b_rsp_valid, b_rsp_err, b_wlv, b_busy;
    logic [31:0] b_rdata, b_wlpc, b_wla, b_wld;

    int checks = 0;
    int errors = 0;

    data_mem_ctrl #(.DEPTH_WORDS(16), .RD_LAT(1), .CLEAR_ON_RESET(1)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .i_req_valid(req_valid && !sel), .o_req_ready(a_ready),
        .i_req_we(req_we), .i_req_width(req_width), .i_req_sign(req_sign),
        .i_req_addr(req_addr), .i_req_wdata(req_wdata), .i_req_pc(req_pc),
        .o_rsp_valid(a_rsp_valid), .o_rsp_rdata(a_rdata), .o_rsp_err(a_rsp_err),
        .o_wr_log_valid(a_wlv), .o_wr_log_pc(a_wlpc), .o_wr_log_addr(a_wla),
        .o_wr_log_data(a_wld), .o_init_busy(a_busy));

    data_mem_ctrl #(.DEPTH_WORDS(16), .RD_LAT(3), .CLEAR_ON_RESET(1)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .i_req_valid(req_valid && sel), .o_req_ready(b_ready),
        .i_req_we(req_we), .i_req_width(req_width), .i_req_sign(req_sign),
        .i_req_addr(req_addr), .i_req_wdata(req_wdata), .i_req_pc(req_pc),
        .o_rsp_valid(b_rsp_valid), .o_rsp_rdata(b_rdata), .o_rsp_err(b_rsp_err),
        .o_wr_log_valid(b_wlv), .o_wr_log_pc(b_wlpc), .o_wr_log_addr(b_wla),
        .o_wr_log_data(b_wld), .o_init_busy(b_busy));

    logic        w_ready, w_rsp_valid, w_rsp_err, w_wlv;
    logic [31:0] w_rdata, w_wlpc, w_wla, w_wld;
    assign w_ready     = sel ? b_ready     : a_ready;
    assign w_rsp_valid = sel ? b_rsp_valid : a_rsp_valid;
    assign w_rsp_err   = sel ? b_rsp_err   : a_rsp_err;
    assign w_wlv       = sel ? b_wlv       : a_wlv;
    assign w_rdata     = sel ? b_rdata     : a_rdata;
    assign w_wlpc      = sel ? b_wlpc      : a_wlpc;
    assign w_wla       = sel ? b_wla       : a_wla;
    assign w_wld       = sel ? b_wld       : a_wld;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Issue one request on the selected DUT and check its whole response.
    task automatic txn(input string tag, input logic we, input logic [1:0] width,
                       input logic sign, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [31:0] exp_rdata, input logic exp_err, input int exp_lat,
                       input logic [31:0] exp_wld);
        int          n;
        int          lat;
        logic        ready_ok;
        logic [31:0] rdata, wld, wla, wlpc;
        logic        err, wlv;
        @(negedge clk);
        req_pc    = req_pc + 32'd4;
        req_valid = 1'b1;
        req_we    = we;
        req_width = width;
        req_sign  = sign;
        req_addr  = addr;
        req_wdata = wdata;
        n = 0;
        while (!w_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        req_valid = 1'b0;
        req_we    = ~we;
        req_width = width ^ 2'd1;
        req_sign  = ~sign;
        req_addr  = ~addr;
        req_wdata = ~wdata;
        lat      = 1;
        ready_ok = 1'b1;
        while (!w_rsp_valid && lat < 20) begin
            if (w_ready) ready_ok = 1'b0;
            @(negedge clk);
            lat++;
        end
        if (w_ready) ready_ok = 1'b0;
        rdata = w_rdata;
        err   = w_rsp_err;
        wlv   = w_wlv;
        wld   = w_wld;
        wla   = w_wla;
        wlpc  = w_wlpc;
        @(negedge clk);
        if (w_rsp_valid || !w_ready) ready_ok = 1'b0;
        chk({tag, "_rdata"}, rdata, exp_rdata);
        chk({tag, "_err"}, {31'b0, err}, {31'b0, exp_err});
        chk({tag, "_lat"}, 32'(lat), 32'(exp_lat));
        chk({tag, "_wlv"}, {31'b0, wlv}, {31'b0, we && !exp_err});
        chk({tag, "_ready"}, {31'b0, ready_ok}, 32'd1);
        if (we && !exp_err) begin
            chk({tag, "_wld"}, wld, exp_wld);
            chk({tag, "_wla"}, wla, {addr[31:2], 2'b00});
            chk({tag, "_wlpc"}, wlpc, req_pc);
        end
    endtask

    task automatic wait_init(output int n, output logic bad_ready, output logic bad_rsp);
        n         = 0;
        bad_ready = 1'b0;
        bad_rsp   = 1'b0;
        while (n < 100) begin
            @(posedge clk);
            #1;
            n++;
            if (a_rsp_valid || b_rsp_valid) bad_rsp = 1'b1;
            if (!a_busy) break;
            if (a_ready || b_ready) bad_ready = 1'b1;
        end
    endtask

    initial begin
        int   n;
        logic bad_ready, bad_rsp, mid_rsp;
        rst_n = 1'b0; sel = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_width = W;
        req_sign = 1'b0; req_addr = '0; req_wdata = '0; req_pc = 32'h0000_1000;
        repeat (3) @(negedge clk);
        chk("rst_ready",   {31'b0, a_ready},     32'd0);
        chk("rst_rspv",    {31'b0, a_rsp_valid}, 32'd0);
        chk("rst_rdata",   a_rdata,              32'd0);
        chk("rst_err",     {31'b0, a_rsp_err},   32'd0);
        chk("rst_wlv",     {31'b0, a_wlv},       32'd0);
        chk("rst_wld",     a_wld,                32'd0);
        chk("rst_busy",    {31'b0, a_busy},      32'd1);
        chk("rst_busy_b",  {31'b0, b_busy},      32'd1);
        rst_n = 1'b1;
        wait_init(n, bad_ready, bad_rsp);
        chk("init_cycles",   32'(n), 32'd16);
        chk("init_ready_lo", {31'b0, bad_ready}, 32'd0);
        chk("init_b_done",   {31'b0, b_busy},    32'd0);

        txn("clr_lw3c", 0, W, 0, 32'h3C, 32'h0,        32'h0,        0, 1, 32'h0);
        txn("sw10",     1, W, 0, 32'h10, 32'h11223344, 32'h0,        0, 1, 32'h11223344);
        txn("sb12",     1, B, 0, 32'h12, 32'h000000AB, 32'h0,        0, 1, 32'h11AB3344);
        txn("sh10",     1, H, 0, 32'h10, 32'h0000BEEF, 32'h0,        0, 1, 32'h11ABBEEF);
        txn("sh10b",    1, H, 0, 32'h10, 32'hFFFF80EF, 32'h0,        0, 1, 32'h11AB80EF);
        txn("lb11s",    0, B, 1, 32'h11, 32'h0,        32'hFFFFFF80, 0, 1, 32'h0);
        txn("lb11u",    0, B, 0, 32'h11, 32'h0,        32'h00000080, 0, 1, 32'h0);
        txn("lh12s",    0, H, 1, 32'h12, 32'h0,        32'h000011AB, 0, 1, 32'h0);
        txn("lh10s",    0, H, 1, 32'h10, 32'h0,        32'hFFFF80EF, 0, 1, 32'h0);
        txn("lw10s",    0, W, 1, 32'h10, 32'h0,        32'h11AB80EF, 0, 1, 32'h0);
        txn("lb13s",    0, B, 1, 32'h13, 32'h0,        32'h00000011, 0, 1, 32'h0);
        txn("sw00",     1, W, 0, 32'h00, 32'h0A0B0C0D, 32'h0,        0, 1, 32'h0A0B0C0D);
        txn("lw0e",     0, W, 0, 32'h0E, 32'h0,        32'h0,        1, 1, 32'h0);
        txn("sh01",     1, H, 0, 32'h01, 32'h0000FFFF, 32'h0,        1, 1, 32'h0);
        txn("sw02",     1, W, 0, 32'h02, 32'hFFFFFFFF, 32'h0,        1, 1, 32'h0);
        txn("wid3",     1, 2'd3, 0, 32'h00, 32'hFFFFFFFF, 32'h0,     1, 1, 32'h0);
        txn("lw00",     0, W, 0, 32'h00, 32'h0,        32'h0A0B0C0D, 0, 1, 32'h0);
        txn("sb_wrap",  1, B, 0, 32'h43, 32'h000000EE, 32'h0,        0, 1, 32'hEE0B0C0D);
        txn("lw00_w",   0, W, 0, 32'h00, 32'h0,        32'hEE0B0C0D, 0, 1, 32'h0);

        sel = 1'b1;
        txn("b_lw3c",   0, W, 0, 32'h3C, 32'h0,        32'h0,        0, 3, 32'h0);
        txn("b_sw20",   1, W, 0, 32'h20, 32'h12345678, 32'h0,        0, 1, 32'h12345678);
        txn("b_lw20",   0, W, 0, 32'h20, 32'h0,        32'h12345678, 0, 3, 32'h0);
        txn("b_lh22u",  0, H, 0, 32'h22, 32'h0,        32'h00001234, 0, 3, 32'h0);
        txn("b_lb21s",  0, B, 1, 32'h21, 32'h0,        32'h00000056, 0, 3, 32'h0);
        txn("b_lh23e",  0, H, 0, 32'h23, 32'h0,        32'h0,        1, 1, 32'h0);
        txn("b_sw00",   1, W, 0, 32'h00, 32'h55AA55AA, 32'h0,        0, 1, 32'h55AA55AA);

        // Load on B, then pull reset while it sits in WAIT.
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; req_width = W; req_sign = 1'b0; req_addr = 32'h0;
        n = 0;
        while (!b_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        req_valid = 1'b0;
        mid_rsp = b_rsp_valid;
        rst_n = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (b_rsp_valid) mid_rsp = 1'b1;
        end
        chk("mid_rst_busy", {31'b0, b_busy}, 32'd1);
        rst_n = 1'b1;
        wait_init(n, bad_ready, bad_rsp);
        chk("mid_init_cycles", 32'(n), 32'd16);
        chk("mid_no_rsp", {31'b0, mid_rsp | bad_rsp}, 32'd0);

        txn("b_lw00_clr", 0, W, 0, 32'h00, 32'h0,        32'h0,        0, 3, 32'h0);
        txn("b_sw40",     1, W, 0, 32'h40, 32'hCAFEF00D, 32'h0,        0, 1, 32'hCAFEF00D);
        txn("b_lw00",     0, W, 0, 32'h00, 32'h0,        32'hCAFEF00D, 0, 3, 32'h0);
        sel = 1'b0;
        txn("a_lw10_clr", 0, W, 0, 32'h10, 32'h0,        32'h0,        0, 1, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
